mem_port_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the fetch stage and the memory stage of the 5-stage pipeline. It accepts a fetch request and a load/store request and sequences them onto one request/grant/response memory bus. Byte enables are generated from funct3 and the address low bits. The fetch and memory sides each see a one-cycle valid pulse on completion, which the hazard unit uses to build StallF/StallM.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter_be_gen.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and funct3 codes for the memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Request/grant/response memory bus between arbiter and memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_be_gen.sv
// ============================================================================
// Module  : be_gen
// Brief   : funct3/address -> byte enables, lane-replicated store data and
//           misalign flag. Trap detection enabled by MEM_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module be_gen
    import mem_arb_pkg::*;
(
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wdata,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata_rep,
    output logic             o_misalign
);
    logic w_is_byte;
    logic w_is_half;

    assign w_is_byte = (i_funct3 == F3_B) || (i_funct3 == F3_BU);
    assign w_is_half = (i_funct3 == F3_H) || (i_funct3 == F3_HU);

    // Halfword lane ignores a[0] and words ignore a[1:0]: misaligned
    // addresses are forced to alignment here when no trap is taken.
    always_comb begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        if (w_is_byte) begin
            o_be        = 4'b0001 << i_addr_lo;
            o_wdata_rep = {4{i_wdata[7:0]}};
        end else if (w_is_half) begin
            o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata_rep = {2{i_wdata[15:0]}};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign o_misalign = (w_is_half && i_addr_lo[0]) ||
                        ((i_funct3 == F3_W) && (i_addr_lo != 2'b00));
`else
    assign o_misalign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between fetch and load/store with bounded
//           fetch starvation. Misalign trap via MEM_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int FAIR_MAX = 4,
    parameter int CNT_W    = 3
)(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          if_req,
    input  wire logic [AW-1:0] if_addr,
    output logic      [31:0]   if_rdata,
    output logic               if_valid,
    input  wire logic          dm_req,
    input  wire logic          dm_we,
    input  wire logic [2:0]    dm_funct3,
    input  wire logic [AW-1:0] dm_addr,
    input  wire logic [31:0]   dm_wdata,
    output logic      [31:0]   dm_rdata,
    output logic               dm_valid,
    output logic               dm_misalign,
    mem_port_arbiter_if.master mem,
    output logic               busy
);
    arb_state_t       r_state;
    owner_t           r_owner;
    logic [CNT_W-1:0] r_fair_cnt;

    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic        w_misalign;
    logic        w_grant_if;
    logic        w_arb;
    logic        w_unused_ok;

    be_gen u_be_gen (
        .i_funct3    (dm_funct3),
        .i_addr_lo   (dm_addr[1:0]),
        .i_wdata     (dm_wdata),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_misalign  (w_misalign)
    );

    // No arbitration during a valid pulse: the requester still holds the
    // request for the instruction that is completing this cycle.
    assign w_arb      = (if_req || dm_req) && !if_valid && !dm_valid;
    assign w_grant_if = if_req && (!dm_req || (r_fair_cnt == CNT_W'(FAIR_MAX)));
    assign busy       = (r_state != IDLE);
    assign w_unused_ok = &{1'b0, if_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= OWN_IF;
            r_fair_cnt    <= '0;
            if_rdata      <= '0;
            if_valid      <= 1'b0;
            dm_rdata      <= '0;
            dm_valid      <= 1'b0;
            dm_misalign   <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
        end else begin
            if_valid    <= 1'b0;
            dm_valid    <= 1'b0;
            dm_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        if (w_grant_if || !if_req) begin
                            r_fair_cnt <= '0;
                        end else begin
                            r_fair_cnt <= r_fair_cnt + 1'b1;
                        end
                        if (w_grant_if) begin
                            r_owner       <= OWN_IF;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= 1'b0;
                            mem.mem_addr  <= {if_addr[AW-1:2], 2'b00};
                            mem.mem_be    <= 4'b1111;
                            r_state       <= REQ;
                        end else if (w_misalign) begin
                            r_owner       <= OWN_DM;
                            dm_valid      <= 1'b1;
                            dm_misalign   <= 1'b1;
                        end else begin
                            r_owner       <= OWN_DM;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= dm_we;
                            mem.mem_addr  <= {dm_addr[AW-1:2], 2'b00};
                            mem.mem_be    <= w_be;
                            mem.mem_wdata <= w_wdata_rep;
                            r_state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        if (mem.mem_we) begin
                            dm_valid <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (mem.mem_rvalid) begin
                        if (r_owner == OWN_IF) begin
                            if_rdata <= mem.mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= mem.mem_rdata;
                            dm_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter with a
//           zero-wait memory responder. Honours MEM_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [2:0]  dm_funct3 = 3'b010;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_misalign;
    logic        busy;
    logic        gnt_hold = 1'b0;
    logic [31:0] mem_val = '0;

    int total = 0;
    int bad   = 0;
    bit ok;

    mem_port_arbiter_if #(.AW(32)) mem_bus ();

    mem_port_arbiter #(.AW(32), .FAIR_MAX(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_funct3   (dm_funct3),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .dm_misalign (dm_misalign),
        .mem         (mem_bus.master),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Zero-wait memory: grant on the first request cycle, read data next cycle.
    assign mem_bus.mem_gnt = mem_bus.mem_req & ~gnt_hold;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_bus.mem_rvalid <= 1'b0;
            mem_bus.mem_rdata  <= '0;
        end else begin
            mem_bus.mem_rvalid <= mem_bus.mem_req & mem_bus.mem_gnt & ~mem_bus.mem_we;
            mem_bus.mem_rdata  <= mem_val;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic dm_set(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        dm_req = 1'b1; dm_we = we; dm_funct3 = f3; dm_addr = a; dm_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick; tick;
        chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valids", {29'd0, if_valid, dm_valid, dm_misalign}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_bus.mem_be}, 32'd0);
        chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);
        rst = 1'b0;
        tick;

        // Single word load: valid in the 4th cycle counting the request cycle.
        dm_set(1'b0, F3_W, 32'h104, 32'h0); mem_val = 32'hDEADBEEF;
        chk("ld_c0_req", {31'd0, mem_bus.mem_req}, 32'd0);
        tick;
        chk("ld_c1_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("ld_c1_addr", mem_bus.mem_addr, 32'h104);
        chk("ld_c1_be_we", {27'd0, mem_bus.mem_we, mem_bus.mem_be}, 32'h0F);
        chk("ld_c1_busy", {31'd0, busy}, 32'd1);
        tick;
        chk("ld_c2_valid", {31'd0, dm_valid}, 32'd0);
        tick;
        chk("ld_c3_valid", {31'd0, dm_valid}, 32'd1);
        chk("ld_c3_rdata", dm_rdata, 32'hDEADBEEF);
        dm_req = 1'b0;
        tick;
        chk("ld_c4_pulse", {31'd0, dm_valid}, 32'd0);

        // Byte store at 0x203: lane 3, replicated data, 3-cycle completion.
        dm_set(1'b1, F3_B, 32'h203, 32'h000000A5);
        tick;
        chk("sb_addr", mem_bus.mem_addr, 32'h200);
        chk("sb_be_we", {27'd0, mem_bus.mem_we, mem_bus.mem_be}, 32'h18);
        chk("sb_wdata", mem_bus.mem_wdata, 32'hA5A5A5A5);
        tick;
        chk("sb_valid", {31'd0, dm_valid}, 32'd1);
        chk("sb_req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
        dm_req = 1'b0;
        tick;
        chk("sb_pulse", {30'd0, dm_valid, busy}, 32'd0);

        // Sub-word enables for unsigned loads.
        dm_set(1'b0, F3_BU, 32'h201, 32'h0); mem_val = 32'h0;
        tick;
        chk("lbu_be", {28'd0, mem_bus.mem_be}, 32'h2);
        tick; tick;
        chk("lbu_valid", {31'd0, dm_valid}, 32'd1);
        dm_req = 1'b0;
        tick;
        dm_set(1'b0, F3_HU, 32'h102, 32'h0);
        tick;
        chk("lhu_be", {28'd0, mem_bus.mem_be}, 32'hC);
        tick; tick;
        chk("lhu_valid", {31'd0, dm_valid}, 32'd1);
        dm_req = 1'b0;
        tick;

        // Simultaneous fetch and load: DM first, then IF.
        if_req = 1'b1; if_addr = 32'h40;
        dm_set(1'b0, F3_W, 32'h80, 32'h0); mem_val = 32'h11111111;
        tick;
        chk("sim_first_addr", mem_bus.mem_addr, 32'h80);
        tick; tick;
        chk("sim_dm_valid", {30'd0, if_valid, dm_valid}, 32'd1);
        chk("sim_dm_rdata", dm_rdata, 32'h11111111);
        dm_req = 1'b0; mem_val = 32'h22222222;
        tick;
        chk("sim_gap", {29'd0, mem_bus.mem_req, if_valid, dm_valid}, 32'd0);
        tick;
        chk("sim_if_addr", mem_bus.mem_addr, 32'h40);
        chk("sim_if_be", {27'd0, mem_bus.mem_we, mem_bus.mem_be}, 32'h0F);
        tick; tick;
        chk("sim_if_valid", {30'd0, if_valid, dm_valid}, 32'd2);
        chk("sim_if_rdata", if_rdata, 32'h22222222);
        if_req = 1'b0;
        tick;
        chk("sim_if_pulse", {30'd0, if_valid, dm_valid}, 32'd0);

        // Fairness: four DM grants, IF on the fifth, counter back to 0 after.
        if_req = 1'b1; if_addr = 32'h300;
        dm_set(1'b0, F3_W, 32'h400, 32'h0); mem_val = 32'h5A5A5A5A;
        for (int g = 1; g <= 6; g++) begin
            ok = 1'b0;
            for (int i = 0; i < 16 && !ok; i++) begin
                if (mem_bus.mem_req === 1'b1) ok = 1'b1; else tick;
            end
            chk("fair_req_seen", {31'd0, ok}, 32'd1);
            chk("fair_grant_addr", mem_bus.mem_addr, (g == 5) ? 32'h300 : 32'h400);
            ok = 1'b0;
            for (int i = 0; i < 16 && !ok; i++) begin
                tick;
                if ((if_valid | dm_valid) === 1'b1) ok = 1'b1;
            end
            chk("fair_valid_seen", {31'd0, ok}, 32'd1);
            chk("fair_valid_owner", {30'd0, if_valid, dm_valid}, (g == 5) ? 32'd2 : 32'd1);
            if (g == 5) if_addr = 32'h304;
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick;
        chk("fair_idle", {31'd0, busy}, 32'd0);

        // One wait state on grant: fields hold until accepted.
        gnt_hold = 1'b1;
        dm_set(1'b1, F3_W, 32'h600, 32'h12345678);
        tick;
        chk("ws_c1", {31'd0, mem_bus.mem_req}, 32'd1);
        tick;
        chk("ws_c2_hold", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("ws_c2_addr", mem_bus.mem_addr, 32'h600);
        chk("ws_c2_wdata", mem_bus.mem_wdata, 32'h12345678);
        chk("ws_c2_valid", {31'd0, dm_valid}, 32'd0);
        gnt_hold = 1'b0;
        tick;
        chk("ws_valid", {31'd0, dm_valid}, 32'd1);
        dm_req = 1'b0;
        tick;

        // Reset while waiting for read data: abort with no valid pulse.
        dm_set(1'b0, F3_W, 32'h500, 32'h0); mem_val = 32'hCAFEF00D;
        tick;
        chk("rr_req", {31'd0, mem_bus.mem_req}, 32'd1);
        tick;
        chk("rr_in_resp", {30'd0, mem_bus.mem_req, busy}, 32'd1);
        rst = 1'b1; dm_req = 1'b0;
        #1;
        chk("rr_abort", {30'd0, mem_bus.mem_req, busy}, 32'd0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rr_no_valid", {30'd0, if_valid, dm_valid}, 32'd0);
        end
        dm_set(1'b0, F3_W, 32'h504, 32'h0); mem_val = 32'h0BADF00D;
        tick;
        chk("rr_next_addr", mem_bus.mem_addr, 32'h504);
        tick; tick;
        chk("rr_next_valid", {31'd0, dm_valid}, 32'd1);
        chk("rr_next_rdata", dm_rdata, 32'h0BADF00D);
        dm_req = 1'b0;
        tick;

        // Misaligned halfword store at 0x101.
        dm_set(1'b1, F3_H, 32'h101, 32'h0000BEEF);
        tick;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_trap", {29'd0, mem_bus.mem_req, dm_misalign, dm_valid}, 32'd3);
        dm_req = 1'b0;
        tick;
        chk("mis_pulse", {29'd0, mem_bus.mem_req, dm_misalign, dm_valid}, 32'd0);
`else
        chk("mis_addr", mem_bus.mem_addr, 32'h100);
        chk("mis_be", {27'd0, mem_bus.mem_we, mem_bus.mem_be}, 32'h13);
        chk("mis_wdata", mem_bus.mem_wdata, 32'hBEEFBEEF);
        tick;
        chk("mis_valid", {30'd0, dm_misalign, dm_valid}, 32'd1);
        dm_req = 1'b0;
        tick;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
